ram_bridge: RTL and testbench
=============================

# ram_bridge

Single-port memory bridge between the core's `ram_rw` request port and the simulation `RAMHelper` 64-bit dword array. It accepts one byte/half/word/dword request at a time and performs:
- address-to-index translation and byte-lane alignment;
- write-mask expansion and read-data extraction;
- error detection.

It returns a one-cycle `ready` pulse with registered read data, which replaces the ad-hoc glue between core and RAM in the top level.

## Interface
- `PC_START`, 64'h8000_0000, base address mapped to RAM index 0
- `IDX_W`, 16, RAM index width; RAM spans `2^IDX_W` dwords
- `UART_ADDR`, 64'h1000_0000, byte address of UART TX register (used only with the macro)

Ports:
- `clock` in 1 — clock
- `reset` in 1 — reset, synchronous, active-high
- `req_cen_i` in 1 — request valid; core holds it until `resp_ready_o`
- `req_wen_i` in 1 — 1 = store, 0 = load
- `req_addr_i` in 64 — byte address
- `req_wdata_i` in 64 — store data, right-justified
- `req_wmask_i` in 8 — byte enables, right-justified
- `req_size_i` in 3 — 0 = byte, 1 = half, 2 = word, 3 = dword; 4–7 are illegal
- `resp_ready_o` out 1 — one-cycle completion pulse
- `resp_data_o` out 64 — load data, right-justified, zero-extended
- `resp_err_o` out 1 — valid with `resp_ready_o`; misaligned, illegal size or out of range
- `ram_en_o` out 1 — `RAMHelper` enable
- `ram_wen_o` out 1 — `RAMHelper` write enable
- `ram_idx_o` out `IDX_W` — `RAMHelper` read/write index
- `ram_wdata_o` out 64 — lane-aligned write data
- `ram_wmask_o` out 64 — bit mask, each byte enable replicated ×8
- `ram_rdata_i` in 64 — `RAMHelper` read data, combinational on index
- `uart_out_valid_o` out 1 — UART character strobe
- `uart_out_ch_o` out 8 — UART character

## Operation
FSM states are IDLE, ACCESS and RESP.
- **IDLE**
  - If `req_cen_i`: latch all request fields, compute `off = addr[2:0]`, compute `err`, go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - If `!err`: `ram_en_o = 1`, `ram_idx_o = ((addr - PC_START) >> 3)[IDX_W-1:0]`, `ram_wen_o = wen`.
  - `resp_data_o <= (ram_rdata_i >> (off*8))` masked to `8<<size` bits. This capture happens for loads only; for stores `resp_data_o` holds its value.
  - Go to RESP.
- **RESP**
  - `resp_ready_o = 1`, `resp_err_o = err`, go to IDLE.
  - `req_cen_i` is ignored in this cycle.

Write path:
- `ram_wdata_o = wdata << (off*8)`.
- Byte mask = `(wmask & ((1<<(1<<size))-1)) << off`, truncated to 8 bits, expanded ×8 into `ram_wmask_o`.

`err` is set for any of:
- `addr[size-1:0] != 0` (misaligned);
- `size > 3`;
- `addr < PC_START`;
- `(addr - PC_START) >> 3 >= 2^IDX_W`.

When `err` is set:
- `ram_en_o` stays 0 and no write occurs;
- `resp_data_o` = 0.

`ram_en_o`, `ram_wen_o`, `ram_idx_o`, `ram_wdata_o` and `ram_wmask_o` are 0 outside ACCESS.

## Timing
- Request seen in IDLE at cycle N → RAM access at N+1 → `resp_ready_o` at N+2. Maximum throughput is one request per 3 cycles.
- `ram_en_o` is high for exactly one cycle per legal request. It is never high with `err`.
- If `req_cen_i` is still high in the cycle after RESP, it is treated as a new request.
- Reset values: FSM = IDLE, and every output is 0.
- Reset asserted in ACCESS or RESP aborts the request: no `ready` pulse, no further RAM write.
- A write already issued in ACCESS is not undone by reset.

## Configuration
- `RAM_BRIDGE_UART_EN` defined:
  - A legal byte store to `UART_ADDR` bypasses RAM. `ram_en_o` stays 0, and in ACCESS `uart_out_valid_o = 1` for one cycle with `uart_out_ch_o = wdata[7:0]`.
  - A load from `UART_ADDR` returns 0 with no error.
  - A non-byte access to `UART_ADDR` sets `err`.
- `RAM_BRIDGE_UART_EN` undefined:
  - `uart_out_valid_o` and `uart_out_ch_o` are tied to 0.
  - `UART_ADDR` is an ordinary out-of-range address and sets `err`.

## Test plan
- Dword store 64'h1122334455667788 to 0x8000_0010, size 3, wmask 8'hFF.
  - Required: `ram_idx_o` = 2 and `ram_wmask_o` = all ones at N+1.
  - Required: `ready` at N+2 with `err` = 0.
- Byte load at 0x8000_0013, RAM dword = 64'h1122334455667788.
  - Required: `resp_data_o` = 64'h0000_0000_0000_0055 at N+2.
- Half store 16'hBEEF at 0x8000_0006.
  - Required: `ram_wdata_o[63:48]` = 16'hBEEF and `ram_wmask_o` = 64'hFFFF_0000_0000_0000.
- Word load at 0x8000_0002 (misaligned) or at 0x7FFF_FFF8.
  - Required: `ram_en_o` never high; `ready` at N+2 with `err` = 1 and data = 0.
- Reset pulsed in the ACCESS cycle of a load.
  - Required: no `resp_ready_o`; all outputs 0 the cycle after reset.
  - Required: a new request completes normally afterwards.
- `RAM_BRIDGE_UART_EN` defined, byte store 8'h41 to 0x1000_0000.
  - Required: `uart_out_valid_o` for one cycle with `uart_out_ch_o` = 8'h41, `ram_en_o` = 0, `err` = 0.

Source files
------------

// File: rtl/ram_bridge.sv
// Single-port bridge from the core ram_rw request port to the 64-bit RAMHelper dword array.
// Optional UART TX bypass at UART_ADDR is compiled in with `define RAM_BRIDGE_UART_EN.
//
// state  | meaning
// IDLE   | waiting for req_cen_i, latches the request and its error status
// ACCESS | drives the RAMHelper port (or UART strobe), captures load data
// RESP   | one-cycle resp_ready_o pulse with resp_err_o
module ram_bridge #(
  parameter logic [63:0] PC_START  = 64'h8000_0000,
  parameter int          IDX_W     = 16,
  parameter logic [63:0] UART_ADDR = 64'h1000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_cen_i,
  input  logic              req_wen_i,
  input  logic [63:0]       req_addr_i,
  input  logic [63:0]       req_wdata_i,
  input  logic [7:0]        req_wmask_i,
  input  logic [2:0]        req_size_i,
  output logic              resp_ready_o,
  output logic [63:0]       resp_data_o,
  output logic              resp_err_o,
  output logic              ram_en_o,
  output logic              ram_wen_o,
  output logic [IDX_W-1:0]  ram_idx_o,
  output logic [63:0]       ram_wdata_o,
  output logic [63:0]       ram_wmask_o,
  input  logic [63:0]       ram_rdata_i,
  output logic              uart_out_valid_o,
  output logic [7:0]        uart_out_ch_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       state;
  logic             wen_q;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       off_q;
  logic [1:0]       size_q;
  logic [63:0]      wdata_q;
  logic [7:0]       wmask_q;
  logic             err_q;
  logic             uart_q;

  logic [63:0] dw_idx;
  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_uart;
  logic        req_err;

  assign dw_idx = (req_addr_i - PC_START) >> 3;

`ifdef RAM_BRIDGE_UART_EN
  assign req_uart = (req_addr_i == UART_ADDR);
`else
  assign req_uart = 1'b0;
`endif

  always_comb begin
    req_misaligned = 1'b0;
    case (req_size_i)
      3'd1:    req_misaligned = req_addr_i[0];
      3'd2:    req_misaligned = |req_addr_i[1:0];
      3'd3:    req_misaligned = |req_addr_i[2:0];
      default: req_misaligned = 1'b0;
    endcase
    req_out_of_range = (req_addr_i < PC_START) || (dw_idx >= (64'd1 << IDX_W));
    // The UART register only accepts byte accesses and is outside the RAM window.
    if (req_uart)
      req_err = (req_size_i != 3'd0);
    else
      req_err = req_misaligned || req_size_i[2] || req_out_of_range;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      wen_q   <= 1'b0;
      idx_q   <= '0;
      off_q   <= 3'd0;
      size_q  <= 2'd0;
      wdata_q <= 64'd0;
      wmask_q <= 8'd0;
      err_q   <= 1'b0;
      uart_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_cen_i) begin
            wen_q   <= req_wen_i;
            idx_q   <= dw_idx[IDX_W-1:0];
            off_q   <= req_addr_i[2:0];
            size_q  <= req_size_i[1:0];
            wdata_q <= req_wdata_i;
            wmask_q <= req_wmask_i;
            err_q   <= req_err;
            uart_q  <= req_uart;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: state <= S_RESP;
        S_RESP:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  logic        in_access;
  logic        ram_go;
  logic [7:0]  size_lanes;
  logic [7:0]  byte_mask;
  logic [63:0] rd_shift;
  logic [63:0] rd_data;

  assign in_access = (state == S_ACCESS);
  assign ram_go    = in_access && !err_q && !uart_q;

  always_comb begin
    size_lanes = 8'h01;
    rd_data    = 64'd0;
    rd_shift   = ram_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'd0: begin size_lanes = 8'h01; rd_data = {56'd0, rd_shift[7:0]};  end
      2'd1: begin size_lanes = 8'h03; rd_data = {48'd0, rd_shift[15:0]}; end
      2'd2: begin size_lanes = 8'h0F; rd_data = {32'd0, rd_shift[31:0]}; end
      default: begin size_lanes = 8'hFF; rd_data = rd_shift; end
    endcase
    byte_mask = (wmask_q & size_lanes) << off_q;
  end

  always_comb begin
    ram_en_o    = ram_go;
    ram_wen_o   = ram_go && wen_q;
    ram_idx_o   = ram_go ? idx_q : '0;
    ram_wdata_o = ram_go ? (wdata_q << {off_q, 3'b000}) : 64'd0;
    ram_wmask_o = 64'd0;
    for (int i = 0; i < 8; i++)
      ram_wmask_o[8*i +: 8] = {8{ram_go && byte_mask[i]}};
  end

  // Stores keep the previous load data; errors and UART loads return zero.
  always_ff @(posedge clock) begin
    if (reset)
      resp_data_o <= 64'd0;
    else if (in_access) begin
      if (err_q)
        resp_data_o <= 64'd0;
      else if (!wen_q)
        resp_data_o <= uart_q ? 64'd0 : rd_data;
    end
  end

  assign resp_ready_o = (state == S_RESP);
  assign resp_err_o   = (state == S_RESP) && err_q;

`ifdef RAM_BRIDGE_UART_EN
  assign uart_out_valid_o = in_access && uart_q && !err_q && wen_q;
  assign uart_out_ch_o    = uart_out_valid_o ? wdata_q[7:0] : 8'd0;
`else
  assign uart_out_valid_o = 1'b0;
  assign uart_out_ch_o    = 8'd0;
`endif

endmodule

// File: tb/tb_ram_bridge.sv
// Self-checking bench for ram_bridge: scoreboard of expected responses plus per-test
// checks of the RAM port during ACCESS, with a small dword memory behind the bridge.
module tb_ram_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_cen_i = 1'b0;
  logic        req_wen_i = 1'b0;
  logic [63:0] req_addr_i = 64'd0;
  logic [63:0] req_wdata_i = 64'd0;
  logic [7:0]  req_wmask_i = 8'd0;
  logic [2:0]  req_size_i = 3'd0;
  logic        resp_ready_o;
  logic [63:0] resp_data_o;
  logic        resp_err_o;
  logic        ram_en_o;
  logic        ram_wen_o;
  logic [15:0] ram_idx_o;
  logic [63:0] ram_wdata_o;
  logic [63:0] ram_wmask_o;
  logic [63:0] ram_rdata_i;
  logic        uart_out_valid_o;
  logic [7:0]  uart_out_ch_o;

  ram_bridge dut (
    .clock(clock), .reset(reset),
    .req_cen_i(req_cen_i), .req_wen_i(req_wen_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i), .req_size_i(req_size_i),
    .resp_ready_o(resp_ready_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .ram_en_o(ram_en_o), .ram_wen_o(ram_wen_o), .ram_idx_o(ram_idx_o),
    .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o), .ram_rdata_i(ram_rdata_i),
    .uart_out_valid_o(uart_out_valid_o), .uart_out_ch_o(uart_out_ch_o)
  );

  always #5 clock = ~clock;

  logic [63:0] mem [16] = '{default: 64'd0};
  assign ram_rdata_i = mem[ram_idx_o[3:0]];
  always @(posedge clock)
    if (ram_en_o && ram_wen_o)
      mem[ram_idx_o[3:0]] <= (mem[ram_idx_o[3:0]] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [63:0] data;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int passed = 0;
  int ready_seen = 0;
  int en_count = 0;

  always @(negedge clock) begin
    if (ram_en_o) en_count++;
    if (resp_ready_o) begin
      exp_t e;
      ready_seen++;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_ready: got ready=1, required no response pending");
      end else begin
        passed++;
        e = sb.pop_front();
        total++;
        if (resp_err_o !== e.err)
          $display("FAIL resp_err: got %0b required %0b", resp_err_o, e.err);
        else passed++;
        if (e.chk_data) begin
          total++;
          if (resp_data_o !== e.data)
            $display("FAIL resp_data: got %h required %h", resp_data_o, e.data);
          else passed++;
        end
      end
    end
  end

  task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask, input logic [2:0] size,
                       input logic push, input logic err, input logic chk, input logic [63:0] data);
    exp_t e;
    if (push) begin
      e.err = err; e.chk_data = chk; e.data = data;
      sb.push_back(e);
    end
    req_wen_i = wen; req_addr_i = addr; req_wdata_i = wdata;
    req_wmask_i = wmask; req_size_i = size; req_cen_i = 1'b1;
    @(posedge clock); #1;
    req_cen_i = 1'b0;
    @(negedge clock);
  endtask

  task automatic finish_req;
    @(posedge clock);
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (resp_ready_o !== 1'b0) $display("FAIL rst_ready: got %0b required 0", resp_ready_o); else passed++;
    total++; if (resp_data_o !== 64'd0) $display("FAIL rst_data: got %h required 0", resp_data_o); else passed++;
    total++; if ({ram_en_o, ram_wen_o, ram_idx_o, ram_wmask_o} !== 82'd0)
      $display("FAIL rst_ram: got en=%0b idx=%h required all 0", ram_en_o, ram_idx_o); else passed++;
    total++; if ({uart_out_valid_o, uart_out_ch_o, resp_err_o} !== 10'd0)
      $display("FAIL rst_uart: got %0b/%h required 0", uart_out_valid_o, uart_out_ch_o); else passed++;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_dword_store;
    issue(1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 3'd3, 1'b1, 1'b0, 1'b0, 64'd0);
    total++; if (ram_en_o !== 1'b1 || ram_wen_o !== 1'b1)
      $display("FAIL dstore_en: got en=%0b wen=%0b required 1/1", ram_en_o, ram_wen_o); else passed++;
    total++; if (ram_idx_o !== 16'd2) $display("FAIL dstore_idx: got %h required 2", ram_idx_o); else passed++;
    total++; if (ram_wmask_o !== {64{1'b1}}) $display("FAIL dstore_mask: got %h required all ones", ram_wmask_o); else passed++;
    total++; if (ram_wdata_o !== 64'h1122334455667788) $display("FAIL dstore_wdata: got %h", ram_wdata_o); else passed++;
    finish_req();
  endtask

  task automatic test_byte_load;
    issue(1'b0, 64'h8000_0013, 64'd0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 64'h55);
    total++; if (ram_en_o !== 1'b1 || ram_wen_o !== 1'b0 || ram_idx_o !== 16'd2)
      $display("FAIL bload_port: got en=%0b wen=%0b idx=%h required 1/0/2", ram_en_o, ram_wen_o, ram_idx_o); else passed++;
    finish_req();
  endtask

  task automatic test_half_store;
    issue(1'b1, 64'h8000_0006, 64'hBEEF, 8'h03, 3'd1, 1'b1, 1'b0, 1'b0, 64'd0);
    total++; if (ram_wdata_o[63:48] !== 16'hBEEF) $display("FAIL hstore_wdata: got %h required beef", ram_wdata_o[63:48]); else passed++;
    total++; if (ram_wmask_o !== 64'hFFFF_0000_0000_0000) $display("FAIL hstore_mask: got %h", ram_wmask_o); else passed++;
    total++; if (ram_idx_o !== 16'd0) $display("FAIL hstore_idx: got %h required 0", ram_idx_o); else passed++;
    finish_req();
    issue(1'b0, 64'h8000_0006, 64'd0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1, 64'hBEEF);
    finish_req();
    issue(1'b0, 64'h8000_0004, 64'd0, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1, 64'hBEEF_0000);
    finish_req();
  endtask

  task automatic test_errors;
    logic [63:0] addrs [5] = '{64'h8000_0002, 64'h7FFF_FFF8, 64'h8008_0000, 64'h8000_0000, 64'h1000_0000};
    logic [2:0]  sizes [5] = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd2};
    logic        wens  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int en0;
    for (int i = 0; i < 5; i++) begin
      en0 = en_count;
      issue(wens[i], addrs[i], 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, sizes[i], 1'b1, 1'b1, 1'b1, 64'd0);
      finish_req();
      total++; if (en_count !== en0) $display("FAIL err_en_%0d: got %0d enables required 0", i, en_count - en0); else passed++;
    end
  endtask

  task automatic test_boundary;
    issue(1'b1, 64'h8007_FFF8, 64'hCAFE_F00D_1234_5678, 8'hFF, 3'd3, 1'b1, 1'b0, 1'b0, 64'd0);
    total++; if (ram_idx_o !== 16'hFFFF || ram_en_o !== 1'b1)
      $display("FAIL top_idx: got idx=%h en=%0b required ffff/1", ram_idx_o, ram_en_o); else passed++;
    finish_req();
    issue(1'b0, 64'h8007_FFF8, 64'd0, 8'h00, 3'd3, 1'b1, 1'b0, 1'b1, 64'hCAFE_F00D_1234_5678);
    finish_req();
  endtask

  task automatic test_reset_abort;
    int r0;
    r0 = ready_seen;
    issue(1'b0, 64'h8000_0010, 64'd0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    total++; if (resp_ready_o !== 1'b0) $display("FAIL abort_ready: got 1 required 0"); else passed++;
    total++; if (resp_data_o !== 64'd0 || ram_en_o !== 1'b0)
      $display("FAIL abort_outs: got data=%h en=%0b required 0", resp_data_o, ram_en_o); else passed++;
    repeat (3) @(posedge clock);
    #1;
    total++; if (ready_seen !== r0) $display("FAIL abort_noresp: got %0d readies required 0", ready_seen - r0); else passed++;
    issue(1'b0, 64'h8000_0006, 64'd0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1, 64'hBEEF);
    finish_req();
  endtask

  task automatic test_back_to_back;
    int r0, e0;
    exp_t e;
    r0 = ready_seen; e0 = en_count;
    e.err = 1'b0; e.chk_data = 1'b1; e.data = 64'h1122334455667788;
    sb.push_back(e); sb.push_back(e);
    req_wen_i = 1'b0; req_addr_i = 64'h8000_0010; req_size_i = 3'd3; req_cen_i = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    req_cen_i = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (ready_seen - r0 !== 2) $display("FAIL b2b_ready: got %0d readies required 2", ready_seen - r0); else passed++;
    total++; if (en_count - e0 !== 2) $display("FAIL b2b_en: got %0d enables required 2", en_count - e0); else passed++;
  endtask

  task automatic test_uart;
`ifdef RAM_BRIDGE_UART_EN
    issue(1'b1, 64'h1000_0000, 64'h41, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, 64'd0);
    total++; if (uart_out_valid_o !== 1'b1 || uart_out_ch_o !== 8'h41)
      $display("FAIL uart_strobe: got %0b/%h required 1/41", uart_out_valid_o, uart_out_ch_o); else passed++;
    total++; if (ram_en_o !== 1'b0) $display("FAIL uart_ram_en: got 1 required 0"); else passed++;
    @(negedge clock);
    total++; if (uart_out_valid_o !== 1'b0) $display("FAIL uart_one_cycle: got 1 required 0"); else passed++;
    @(posedge clock); #1;
`else
    issue(1'b1, 64'h1000_0000, 64'h41, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1, 64'd0);
    total++; if (uart_out_valid_o !== 1'b0 || ram_en_o !== 1'b0)
      $display("FAIL uart_off: got valid=%0b en=%0b required 0/0", uart_out_valid_o, ram_en_o); else passed++;
    finish_req();
`endif
  endtask

  initial begin
    test_reset();
    test_dword_store();
    test_byte_load();
    test_half_store();
    test_errors();
    test_boundary();
    test_reset_abort();
    test_back_to_back();
    test_uart();
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending responses required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
